// File: rtl/tdl_mc.sv
// Multichannel time-division-multiplexed tapped delay line with per-channel fill tracking.
// Optional macro TDL_MC_FILL_GATE_EN suppresses tap vectors until the written channel is full.
//
// Per-channel fill state:
//   state   | meaning
//   FILLING | fewer than TAPS samples received since reset/flush
//   FULL    | TAPS or more samples received; held until reset/flush
module tdl_mc #(
  parameter int DATA_WIDTH = 13,
  parameter int TAPS       = 8,
  parameter int CHANNELS   = 4,
  localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         VIN,
  input  logic signed [DATA_WIDTH-1:0] DIN,
  input  logic                         FLUSH,
  output logic                         VOUT,
  output logic        [CW-1:0]         CH_OUT,
  output logic signed [DATA_WIDTH-1:0] TP [0:TAPS-1],
  output logic                         FILLED
);

  localparam int CNTW = $clog2(TAPS + 1);

`ifdef TDL_MC_FILL_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  typedef enum logic {FILLING = 1'b0, FULL = 1'b1} fill_t;

  logic signed [DATA_WIDTH-1:0] line [CHANNELS][TAPS];
  logic signed [DATA_WIDTH-1:0] nt   [TAPS];
  logic        [CNTW-1:0]       cnt  [CHANNELS];
  fill_t                        fill_st [CHANNELS];
  fill_t                        fill_nx [CHANNELS];
  logic        [CW-1:0]         ch_ptr;
  logic        [CNTW-1:0]       cnt_inc;
  logic                         full_after;
  logic                         emit;

  // Post-shift image of the channel being written; this is what gets presented.
  always_comb begin
    nt[0] = DIN;
    for (int k = 1; k < TAPS; k++) nt[k] = line[ch_ptr][k-1];
  end

  always_comb begin
    cnt_inc    = (cnt[ch_ptr] == CNTW'(TAPS)) ? cnt[ch_ptr] : cnt[ch_ptr] + CNTW'(1);
    full_after = (cnt_inc == CNTW'(TAPS));
    emit       = VIN && (!GATE || full_after);
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      fill_nx[c] = fill_st[c];
      if (FLUSH)
        fill_nx[c] = FILLING;
      else if (VIN && (CW'(c) == ch_ptr) && full_after)
        fill_nx[c] = FULL;
    end
  end

  always_ff @(posedge CLK) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (RST) fill_st[c] <= FILLING;
      else     fill_st[c] <= fill_nx[c];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      ch_ptr <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cnt[c] <= '0;
        for (int k = 0; k < TAPS; k++) line[c][k] <= '0;
      end
    end else if (VIN) begin
      for (int k = 0; k < TAPS; k++) line[ch_ptr][k] <= nt[k];
      cnt[ch_ptr] <= cnt_inc;
      ch_ptr      <= (ch_ptr == CW'(CHANNELS - 1)) ? '0 : ch_ptr + CW'(1);
    end
  end

  // Presented vector only changes on an emitted sample; flush clears it like reset.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      VOUT   <= 1'b0;
      CH_OUT <= '0;
      FILLED <= 1'b0;
      for (int k = 0; k < TAPS; k++) TP[k] <= '0;
    end else begin
      VOUT <= emit;
      if (emit) begin
        CH_OUT <= ch_ptr;
        FILLED <= full_after;
        for (int k = 0; k < TAPS; k++) TP[k] <= nt[k];
      end
    end
  end

endmodule

// File: tb/tb_tdl_mc.sv
// Self-checking bench for tdl_mc: queue-style channel model checked every cycle,
// plus directed literal expectations. Honours TDL_MC_FILL_GATE_EN like the DUT.
module tb_tdl_mc;
  localparam int DW = 13;
  localparam int NT = 8;
  localparam int NC = 4;
  localparam int CW = 2;

`ifdef TDL_MC_FILL_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST, VIN, FLUSH;
  logic signed [DW-1:0] DIN;
  logic                 VOUT, FILLED;
  logic        [CW-1:0] CH_OUT;
  logic signed [DW-1:0] TP [0:NT-1];

  tdl_mc #(.DATA_WIDTH(DW), .TAPS(NT), .CHANNELS(NC)) dut (
    .CLK(CLK), .RST(RST), .VIN(VIN), .DIN(DIN), .FLUSH(FLUSH),
    .VOUT(VOUT), .CH_OUT(CH_OUT), .TP(TP), .FILLED(FILLED)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: each channel is a history list, newest first; fill count is samples seen.
  int m_hist [NC][NT];
  int m_fill [NC];
  int m_ptr;
  int e_vout, e_ch, e_filled;
  int e_tp [NT];
  bit started = 0;

  always @(posedge CLK) begin
    started = 1;
    if (RST || FLUSH) begin
      for (int c = 0; c < NC; c++) begin
        m_fill[c] = 0;
        for (int k = 0; k < NT; k++) m_hist[c][k] = 0;
      end
      m_ptr = 0; e_vout = 0; e_ch = 0; e_filled = 0;
      for (int k = 0; k < NT; k++) e_tp[k] = 0;
    end else if (VIN) begin
      for (int k = NT - 1; k > 0; k--) m_hist[m_ptr][k] = m_hist[m_ptr][k-1];
      m_hist[m_ptr][0] = int'(DIN);
      if (m_fill[m_ptr] < NT) m_fill[m_ptr]++;
      e_vout = (!GATE || m_fill[m_ptr] == NT) ? 1 : 0;
      if (e_vout == 1) begin
        e_ch = m_ptr;
        e_filled = (m_fill[m_ptr] == NT) ? 1 : 0;
        for (int k = 0; k < NT; k++) e_tp[k] = m_hist[m_ptr][k];
      end
      m_ptr = (m_ptr + 1) % NC;
    end else begin
      e_vout = 0;
    end
  end

  // Log of presented vectors for the directed literal checks.
  int               log_ch [$];
  int               log_fl [$];
  logic [NT*DW-1:0] log_tp [$];

  always @(negedge CLK) begin
    if (started) begin
      chk("vout", int'(VOUT), e_vout);
      chk("ch_out", int'(CH_OUT), e_ch);
      chk("filled", int'(FILLED), e_filled);
      for (int k = 0; k < NT; k++) chk($sformatf("tp%0d", k), int'(TP[k]), e_tp[k]);
      if (VOUT) begin
        logic [NT*DW-1:0] v;
        for (int k = 0; k < NT; k++) v[k*DW +: DW] = TP[k];
        log_ch.push_back(int'(CH_OUT));
        log_fl.push_back(int'(FILLED));
        log_tp.push_back(v);
      end
    end
  end

  function automatic int ltap(input int idx, input int k);
    logic [NT*DW-1:0] v;
    logic signed [DW-1:0] t;
    v = log_tp[idx];
    t = v[k*DW +: DW];
    return int'(t);
  endfunction

  task automatic drive(input bit r, input bit v, input int d, input bit f);
    @(posedge CLK);
    #1;
    RST = r; VIN = v; DIN = DW'(d); FLUSH = f;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  task automatic clear_log();
    log_ch.delete(); log_fl.delete(); log_tp.delete();
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0);
    idle(1);
    clear_log();
  endtask

  initial begin
    RST = 1'b1; VIN = 1'b1; DIN = 13'sd5; FLUSH = 1'b0;
    // Reset with a sample present, then first post-reset sample is accepted.
    drive(1, 1, 5, 0);
    drive(0, 1, 5, 0);
    @(negedge CLK);
    chk("rst_vout", int'(VOUT), 0);
    chk("rst_tp0", int'(TP[0]), 0);
    chk("rst_ch", int'(CH_OUT), 0);
    chk("rst_filled", int'(FILLED), 0);
    clear_log();
    idle(3);
    chk("post_rst_count", log_ch.size(), GATE ? 0 : 1);
    if (!GATE && log_ch.size() == 1) begin
      chk("post_rst_ch", log_ch[0], 0);
      chk("post_rst_tp0", ltap(0, 0), 5);
    end

    // Interleave / fill / wrap with 1..32, then a negative full-scale sample.
    do_reset();
    for (int i = 1; i <= 32; i++) drive(0, 1, i, 0);
    idle(2);
    if (!GATE) begin
      chk("stream_count", log_ch.size(), 32);
      if (log_ch.size() == 32) begin
        chk("out5_ch", log_ch[4], 0);
        chk("out5_tp0", ltap(4, 0), 5);
        chk("out5_tp1", ltap(4, 1), 1);
        chk("out8_ch", log_ch[7], 3);
        chk("out8_tp0", ltap(7, 0), 8);
        chk("out8_tp1", ltap(7, 1), 4);
        chk("out8_tp2", ltap(7, 2), 0);
        chk("out28_filled", log_fl[27], 0);
        chk("out29_filled", log_fl[28], 1);
        for (int k = 0; k < NT; k++) chk($sformatf("out32_tp%0d", k), ltap(31, k), 32 - 4 * k);
      end
    end else begin
      chk("gate_count", log_ch.size(), 4);
      if (log_ch.size() == 4) begin
        chk("gate_first_ch", log_ch[0], 0);
        chk("gate_first_filled", log_fl[0], 1);
        for (int k = 0; k < NT; k++) chk($sformatf("gate_first_tp%0d", k), ltap(0, k), 29 - 4 * k);
      end
    end
    clear_log();
    drive(0, 1, -4096, 0);
    idle(2);
    chk("neg_count", log_ch.size(), 1);
    if (log_ch.size() == 1) chk("neg_tp0", ltap(0, 0), -4096);

    // Gaps between samples.
    do_reset();
    drive(0, 1, 7, 0);
    drive(0, 0, 123, 0);
    drive(0, 0, 456, 0);
    drive(0, 1, 9, 0);
    idle(3);
    chk("gap_count", log_ch.size(), GATE ? 0 : 2);
    if (!GATE && log_ch.size() == 2) begin
      chk("gap_ch0", log_ch[0], 0);
      chk("gap_ch1", log_ch[1], 1);
      chk("gap_tp0_b", ltap(1, 0), 9);
    end

    // Flush with a colliding sample, then restart.
    do_reset();
    for (int i = 1; i <= 10; i++) drive(0, 1, i, 0);
    drive(0, 1, 99, 1);
    drive(0, 0, 0, 0);
    @(negedge CLK);
    chk("flush_vout", int'(VOUT), 0);
    chk("flush_tp0", int'(TP[0]), 0);
    clear_log();
    drive(0, 1, 3, 0);
    idle(2);
    chk("after_flush_count", log_ch.size(), GATE ? 0 : 1);
    if (!GATE && log_ch.size() == 1) begin
      chk("after_flush_ch", log_ch[0], 0);
      chk("after_flush_tp0", ltap(0, 0), 3);
      chk("after_flush_tp1", ltap(0, 1), 0);
      chk("after_flush_filled", log_fl[0], 0);
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
